// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter/mux slice.
package bus_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;
    localparam int unsigned OH_MAX     = 16;

    // Index of the set bit in a one-hot vector (zero when empty).
    function automatic logic [3:0] oh2idx(input logic [OH_MAX-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < int'(OH_MAX); i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-mask priority encoder: first set req bit at or after ptr, modulo N.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] w_cand;

    // Walk offsets from high to low so the smallest offset from ptr wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_cand = IW'((int'(ptr) + k) % int'(N));
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// N-channel bus arbiter with burst ownership, registered bus data and sticky abort flag.
module bus_arbiter_mux
    import bus_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned N     = 4,
    parameter  int unsigned MODE  = 0,
    localparam int unsigned IW    = $clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic [N*WIDTH-1:0]   din,
    input  logic                 clr_err,
    output logic [N-1:0]         gnt,
    output logic [IW-1:0]        owner,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid,
    output logic                 busy,
    output logic                 err
);

    state_e           r_state;
    logic [N-1:0]     r_gnt;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_rr_ptr;
    logic [WIDTH-1:0] r_bus_out;
    logic             r_bus_valid;
    logic             r_busy;
    logic             r_err;

    logic             w_any;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_ptr;
    logic [N-1:0]     w_onehot;
    logic [IW-1:0]    w_next_ptr;
    logic             w_own_req;
    logic             w_own_last;
    logic [WIDTH-1:0] w_own_data;

    // Fixed priority is the rotating search anchored at channel 0.
    assign w_ptr = (MODE == MODE_FIXED) ? '0 : r_rr_ptr;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (w_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_onehot   = N'(1) << w_idx;
    assign w_next_ptr = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

    // Current owner's request, last marker and data.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_owner == IW'(i)) begin
                w_own_req  = req[i];
                w_own_last = last[i];
                w_own_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_bus_valid <= 1'b0;
            // A set in the same cycle overrides this clear below.
            if (clr_err) r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gnt   <= w_onehot;
                        r_owner <= IW'(oh2idx(OH_MAX'(w_onehot)));
                        r_busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_own_req) begin
                        r_bus_out   <= w_own_data;
                        r_bus_valid <= 1'b1;
                        if (w_own_last) begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            if (MODE == MODE_RR) r_rr_ptr <= w_next_ptr;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        if (MODE == MODE_RR) r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: round-robin N=4, fixed-priority N=4 and round-robin N=2 instances.
module tb_bus_arbiter_mux;

    logic        Clk;
    logic        Reset_n;

    logic [3:0]  req_a, last_a, gnt_a;
    logic [63:0] din_a;
    logic        clr_a, vld_a, busy_a, err_a;
    logic [1:0]  owner_a;
    logic [15:0] bus_a;

    logic [3:0]  req_f, last_f, gnt_f;
    logic [63:0] din_f;
    logic        clr_f, vld_f, busy_f, err_f;
    logic [1:0]  owner_f;
    logic [15:0] bus_f;

    logic [1:0]  req_s, last_s, gnt_s;
    logic [15:0] din_s;
    logic        clr_s, vld_s, busy_s, err_s;
    logic        owner_s;
    logic [7:0]  bus_s;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter_mux #(.WIDTH(16), .N(4), .MODE(0)) u_rr (
        .Clk(Clk), .Reset_n(Reset_n), .req(req_a), .last(last_a), .din(din_a),
        .clr_err(clr_a), .gnt(gnt_a), .owner(owner_a), .bus_out(bus_a),
        .bus_valid(vld_a), .busy(busy_a), .err(err_a)
    );

    bus_arbiter_mux #(.WIDTH(16), .N(4), .MODE(1)) u_fix (
        .Clk(Clk), .Reset_n(Reset_n), .req(req_f), .last(last_f), .din(din_f),
        .clr_err(clr_f), .gnt(gnt_f), .owner(owner_f), .bus_out(bus_f),
        .bus_valid(vld_f), .busy(busy_f), .err(err_f)
    );

    bus_arbiter_mux #(.WIDTH(8), .N(2), .MODE(0)) u_n2 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req_s), .last(last_s), .din(din_s),
        .clr_err(clr_s), .gnt(gnt_s), .owner(owner_s), .bus_out(bus_s),
        .bus_valid(vld_s), .busy(busy_s), .err(err_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        req_a = '0; last_a = '0; din_a = '0; clr_a = 1'b0;
        req_f = '0; last_f = '0; din_f = '0; clr_f = 1'b0;
        req_s = '0; last_s = '0; din_s = '0; clr_s = 1'b0;
        tick();
        tick();
        check("rst_gnt",   32'(gnt_a),   32'h0);
        check("rst_owner", 32'(owner_a), 32'h0);
        check("rst_bus",   32'(bus_a),   32'h0);
        check("rst_vld",   32'(vld_a),   32'h0);
        check("rst_busy",  32'(busy_a),  32'h0);
        check("rst_err",   32'(err_a),   32'h0);
        Reset_n = 1'b1;
        tick();

        // Reset asserted mid-burst on channel 2.
        req_a = 4'b0100;
        din_a[2*16 +: 16] = 16'hC002;
        tick();
        check("mid_gnt",   32'(gnt_a),   32'h4);
        check("mid_owner", 32'(owner_a), 32'h2);
        check("mid_busy",  32'(busy_a),  32'h1);
        tick();
        check("mid_vld", 32'(vld_a), 32'h1);
        check("mid_bus", 32'(bus_a), 32'hC002);
        Reset_n = 1'b0;
        req_a   = '0;
        #1;
        check("arst_gnt",   32'(gnt_a),   32'h0);
        check("arst_owner", 32'(owner_a), 32'h0);
        check("arst_bus",   32'(bus_a),   32'h0);
        check("arst_vld",   32'(vld_a),   32'h0);
        check("arst_busy",  32'(busy_a),  32'h0);
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        check("post_gnt",  32'(gnt_a),  32'h0);
        check("post_busy", 32'(busy_a), 32'h0);
        check("post_vld",  32'(vld_a),  32'h0);

        // Round-robin with all requesting, single-beat bursts.
        din_a  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        req_a  = 4'b1111;
        last_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_gnt",   32'(gnt_a),   32'(4'b0001 << (g % 4)));
            check("rr_owner", 32'(owner_a), 32'(g % 4));
            tick();
            check("rr_gap", 32'(gnt_a), 32'h0);
            check("rr_vld", 32'(vld_a), 32'h1);
            check("rr_bus", 32'(bus_a), 32'(16'hD000 + 16'(g % 4)));
        end
        req_a  = '0;
        last_a = '0;
        tick();

        // Three-beat burst on channel 0.
        req_a = 4'b0001;
        din_a[0 +: 16] = 16'hA001;
        tick();
        check("b_gnt1", 32'(gnt_a), 32'h1);
        check("b_vld1", 32'(vld_a), 32'h0);
        tick();
        check("b_bus1", 32'(bus_a), 32'hA001);
        check("b_vld2", 32'(vld_a), 32'h1);
        check("b_gnt2", 32'(gnt_a), 32'h1);
        din_a[0 +: 16] = 16'hA002;
        tick();
        check("b_bus2", 32'(bus_a), 32'hA002);
        check("b_gnt3", 32'(gnt_a), 32'h1);
        din_a[0 +: 16] = 16'hA003;
        last_a = 4'b0001;
        tick();
        check("b_bus3",  32'(bus_a),  32'hA003);
        check("b_vld3",  32'(vld_a),  32'h1);
        check("b_gnt4",  32'(gnt_a),  32'h0);
        check("b_busy4", 32'(busy_a), 32'h0);
        req_a  = '0;
        last_a = '0;
        tick();
        check("b_idle_vld",   32'(vld_a),   32'h0);
        check("b_idle_bus",   32'(bus_a),   32'hA003);
        check("b_idle_owner", 32'(owner_a), 32'h0);

        // Owner 3 is not pre-empted, then aborts via a req gap.
        req_a = 4'b1000;
        tick();
        check("np_gnt", 32'(gnt_a), 32'h8);
        check("np_own", 32'(owner_a), 32'h3);
        req_a = 4'b1001;
        din_a[3*16 +: 16] = 16'hB003;
        tick();
        check("np_hold1", 32'(gnt_a), 32'h8);
        check("np_bus",   32'(bus_a), 32'hB003);
        tick();
        check("np_hold2", 32'(gnt_a), 32'h8);
        req_a = 4'b0001;
        tick();
        check("ab_gnt", 32'(gnt_a), 32'h0);
        check("ab_err", 32'(err_a), 32'h1);
        check("ab_vld", 32'(vld_a), 32'h0);
        tick();
        check("ab_next_gnt",   32'(gnt_a),   32'h1);
        check("ab_next_owner", 32'(owner_a), 32'h0);
        last_a = 4'b0001;
        din_a[0 +: 16] = 16'hA00F;
        tick();
        check("ab_ch0_bus", 32'(bus_a), 32'hA00F);
        check("ab_ch0_end", 32'(gnt_a), 32'h0);
        check("ab_err_sticky", 32'(err_a), 32'h1);
        req_a  = '0;
        last_a = '0;

        // Error clear, then set and clear in the same cycle.
        clr_a = 1'b1;
        tick();
        check("clr_err", 32'(err_a), 32'h0);
        clr_a = 1'b0;
        req_a = 4'b0001;
        tick();
        check("sc_gnt", 32'(gnt_a), 32'h1);
        req_a = '0;
        clr_a = 1'b1;
        tick();
        check("sc_set_wins", 32'(err_a), 32'h1);
        clr_a = 1'b0;
        tick();
        check("sc_sticky", 32'(err_a), 32'h1);
        clr_a = 1'b1;
        tick();
        check("sc_cleared", 32'(err_a), 32'h0);
        clr_a = 1'b0;

        // Fixed priority: channel 1 always beats channel 3.
        req_f  = 4'b1010;
        last_f = 4'b1111;
        din_f  = {16'hE003, 16'h0000, 16'hE001, 16'h0000};
        for (int g = 0; g < 3; g++) begin
            tick();
            check("fx_gnt",   32'(gnt_f),   32'h2);
            check("fx_owner", 32'(owner_f), 32'h1);
            tick();
            check("fx_gap", 32'(gnt_f), 32'h0);
            check("fx_bus", 32'(bus_f), 32'hE001);
        end
        req_f = 4'b1000;
        tick();
        check("fx3_gnt",   32'(gnt_f),   32'h8);
        check("fx3_owner", 32'(owner_f), 32'h3);
        tick();
        check("fx3_bus", 32'(bus_f), 32'hE003);
        check("fx3_vld", 32'(vld_f), 32'h1);
        req_f = '0;

        // N=2, WIDTH=8 burst, round-robin step and abort.
        req_s = 2'b01;
        din_s[0 +: 8] = 8'hA1;
        tick();
        check("n2_gnt", 32'(gnt_s), 32'h1);
        tick();
        check("n2_bus1", 32'(bus_s), 32'hA1);
        check("n2_vld1", 32'(vld_s), 32'h1);
        din_s[0 +: 8] = 8'hA2;
        tick();
        check("n2_bus2", 32'(bus_s), 32'hA2);
        din_s[0 +: 8] = 8'hA3;
        last_s = 2'b01;
        tick();
        check("n2_bus3", 32'(bus_s), 32'hA3);
        check("n2_end",  32'(gnt_s), 32'h0);
        req_s  = 2'b11;
        last_s = 2'b11;
        din_s[8 +: 8] = 8'hB1;
        tick();
        check("n2_rr_gnt",   32'(gnt_s),   32'h2);
        check("n2_rr_owner", 32'(owner_s), 32'h1);
        tick();
        check("n2_rr_bus", 32'(bus_s), 32'hB1);
        req_s  = 2'b10;
        last_s = 2'b00;
        tick();
        check("n2_ab_gnt", 32'(gnt_s), 32'h2);
        req_s = 2'b00;
        tick();
        check("n2_ab_err",  32'(err_s), 32'h1);
        check("n2_ab_idle", 32'(gnt_s), 32'h0);
        clr_s = 1'b1;
        tick();
        check("n2_clr", 32'(err_s), 32'h0);
        clr_s = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
